xbar_pkt_arbiter: RTL

XBAR_PKT_ARBITER -- requirements
Module: xbar_pkt_arbiter

---
 rtl/xbar_pkt_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/xbar_pkt_arbiter.sv
// xbar_pkt_arbiter: packet-granular arbiter that locks one crossbar input to one output until the packet's last flit.
// Ports: clk_i/rst_i (sync, active-high); valid_i/last_i per input; dst_i packed per-input destination;
//        out_ready_i per output; in_sel_o/out_sel_o crossbar selects; grant_o pop strobe; out_valid_o; busy_o.
// Macro XBAR_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module xbar_pkt_arbiter #(
    parameter  int PORT_N = 5,
    localparam int SEL_W  = $clog2(PORT_N)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [PORT_N-1:0]         valid_i,
    input  logic [PORT_N-1:0]         last_i,
    input  logic [PORT_N*SEL_W-1:0]   dst_i,
    input  logic [PORT_N-1:0]         out_ready_i,
    output logic [SEL_W-1:0]          in_sel_o,
    output logic [SEL_W-1:0]          out_sel_o,
    output logic [PORT_N-1:0]         grant_o,
    output logic [PORT_N-1:0]         out_valid_o,
    output logic                      busy_o
);
    localparam int EXT_N = 1 << SEL_W;
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nxt;
    // Zero-padded to the full selector range so out-of-range destinations index a 0 bit.
    logic [EXT_N-1:0] valid_ext, last_ext, rdy_ext;
    logic [SEL_W-1:0] dst [PORT_N];
    logic [PORT_N-1:0] elig;
    logic [SEL_W-1:0] win;
    logic xfer;
`ifdef XBAR_ARB_RR_EN
    logic [SEL_W-1:0] ptr;
`endif
    assign valid_ext = EXT_N'(valid_i);
    assign last_ext  = EXT_N'(last_i);
    assign rdy_ext   = EXT_N'(out_ready_i);
    always_comb begin
        for (int i = 0; i < PORT_N; i++) begin
            dst[i]  = dst_i[i*SEL_W +: SEL_W];
            elig[i] = valid_i[i] && (int'(dst[i]) < PORT_N) && rdy_ext[dst[i]];
        end
    end
    // Scan from lowest to highest priority so the highest-priority eligible input is written last.
    always_comb begin
        win = '0;
        for (int k = PORT_N - 1; k >= 0; k--) begin
`ifdef XBAR_ARB_RR_EN
            if (elig[(int'(ptr) + k) % PORT_N]) win = SEL_W'((int'(ptr) + k) % PORT_N);
`else
            if (elig[k]) win = SEL_W'(k);
`endif
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            in_sel_o  <= '0;
            out_sel_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |elig) begin
                in_sel_o  <= win;
                out_sel_o <= dst[win];
            end
        end
    end
`ifdef XBAR_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ptr <= '0;
        else if (state == LOCK && state_nxt == IDLE)
            ptr <= (in_sel_o == SEL_W'(PORT_N - 1)) ? '0 : in_sel_o + 1'b1;
    end
`endif
    always_comb begin
        state_nxt = (state == IDLE) ? (|elig ? LOCK : IDLE)
                                    : ((xfer && last_ext[in_sel_o]) ? IDLE : LOCK);
    end
    // Reset gates every output strobe combinationally, not just from the next edge.
    always_comb begin
        busy_o      = state == LOCK && !rst_i;
        xfer        = busy_o && valid_ext[in_sel_o] && rdy_ext[out_sel_o];
        grant_o     = xfer ? PORT_N'(1) << in_sel_o : '0;
        out_valid_o = xfer ? PORT_N'(1) << out_sel_o : '0;
    end
endmodule
